// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the system memory bus between the CPU and one external
// bus master (DMA / debug loader). The CPU owns the bus by default. A request
// stalls the CPU at its next opcode fetch, grants a burst, and then returns the bus.
// Optional feature macro: ARB_BURST_LIMIT_EN (caps each grant at MAX_BURST transfers).
module mem_bus_arbiter #(
  parameter int unsigned ADR_W     = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned HOLDOFF   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  cpu_adr,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_sync,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic              dma_last,
  output logic              dma_gnt,
  input  logic [ADR_W-1:0]  dma_adr,
  input  logic              dma_rw,
  input  logic [DATA_W-1:0] dma_dout,
  output logic [DATA_W-1:0] dma_din,
  output logic [ADR_W-1:0]  mem_adr,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din
);

  localparam int unsigned BURST_W = 8;
  localparam int unsigned HOLD_W  = 4;

  // Reject parameter values the counters cannot represent.
  if (MAX_BURST == 0 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("mem_bus_arbiter: MAX_BURST must be 1..255");
  end
  if (HOLDOFF > 15) begin : g_bad_holdoff
    $error("mem_bus_arbiter: HOLDOFF must be 0..15");
  end

  typedef enum logic [2:0] {
    S_CPU_OWN   = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_TURN      = 3'd2,
    S_DMA_OWN   = 3'd3,
    S_RETURN    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   holdoff_q, holdoff_d;
  logic                cpu_rdy_q, cpu_rdy_d;
  logic                dma_gnt_q, dma_gnt_d;
  logic                burst_hit_c;

`ifdef ARB_BURST_LIMIT_EN
  logic [BURST_W-1:0]  burst_q, burst_d;

  assign burst_hit_c = (burst_q == BURST_W'(MAX_BURST - 1));

  // Burst counter: cleared in TURN, counts every requested cycle while granted.
  always_comb begin
    burst_d = burst_q;
    if (state_q == S_TURN) begin
      burst_d = '0;
    end else if (state_q == S_DMA_OWN && dma_req) begin
      burst_d = burst_q + BURST_W'(1);
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign burst_hit_c = 1'b0;
`endif

  // Next-state, hold-off counter and registered grant/ready decode.
  always_comb begin
    state_d   = state_q;
    holdoff_d = holdoff_q;
    case (state_q)
      S_CPU_OWN: begin
        if (holdoff_q != '0) begin
          holdoff_d = holdoff_q - HOLD_W'(1);
        end else if (dma_req) begin
          state_d = S_HALT_WAIT;
        end
      end
      S_HALT_WAIT: begin
        // A withdrawn request wins over a fetch boundary.
        if (!dma_req) begin
          state_d = S_CPU_OWN;
        end else if (cpu_sync) begin
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        state_d = S_DMA_OWN;
      end
      S_DMA_OWN: begin
        if (!dma_req || dma_last || burst_hit_c) begin
          state_d = S_RETURN;
        end
      end
      S_RETURN: begin
        state_d   = S_CPU_OWN;
        holdoff_d = HOLD_W'(HOLDOFF);
      end
      default: begin
        state_d = S_CPU_OWN;
      end
    endcase
    cpu_rdy_d = (state_d == S_CPU_OWN);
    dma_gnt_d = (state_d == S_DMA_OWN);
  end

  // State, hold-off and handshake output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CPU_OWN;
      holdoff_q <= '0;
      cpu_rdy_q <= 1'b1;
      dma_gnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
      cpu_rdy_q <= cpu_rdy_d;
      dma_gnt_q <= dma_gnt_d;
    end
  end

  assign cpu_rdy = cpu_rdy_q;
  assign dma_gnt = dma_gnt_q;

  // Memory bus mux; turnaround cycles present the CPU address as a read.
  always_comb begin
    mem_adr  = cpu_adr;
    mem_rw   = cpu_rw;
    mem_dout = cpu_dout;
    case (state_q)
      S_HALT_WAIT: begin
        if (dma_req && cpu_sync) begin
          mem_rw = 1'b1;
        end
      end
      S_TURN, S_RETURN: begin
        mem_rw   = 1'b1;
        mem_dout = '0;
      end
      S_DMA_OWN: begin
        mem_adr  = dma_adr;
        mem_rw   = dma_rw;
        mem_dout = dma_dout;
      end
      default: begin
      end
    endcase
  end

  assign cpu_din = mem_din;
  assign dma_din = mem_din;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: a bus-level memory model logs every write, and
// each burst's expected timeline and write set are derived from the request
// length, dma_last position and burst limit.
module tb_mem_bus_arbiter;

  localparam int unsigned HOLD = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam int LIMIT = 16;
`else
  localparam int LIMIT = 1000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_adr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_sync;
  logic        cpu_rdy;
  logic        dma_req;
  logic        dma_last;
  logic        dma_gnt;
  logic [15:0] dma_adr;
  logic        dma_rw;
  logic [7:0]  dma_dout;
  logic [7:0]  dma_din;
  logic [15:0] mem_adr;
  logic        mem_rw;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;

  int passed = 0;
  int total  = 0;

  logic [7:0]  ram [0:65535];
  logic [15:0] wr_adr_q [$];
  logic [7:0]  wr_dat_q [$];

  mem_bus_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_adr  (cpu_adr),
    .cpu_rw   (cpu_rw),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .cpu_sync (cpu_sync),
    .cpu_rdy  (cpu_rdy),
    .dma_req  (dma_req),
    .dma_last (dma_last),
    .dma_gnt  (dma_gnt),
    .dma_adr  (dma_adr),
    .dma_rw   (dma_rw),
    .dma_dout (dma_dout),
    .dma_din  (dma_din),
    .mem_adr  (mem_adr),
    .mem_rw   (mem_rw),
    .mem_dout (mem_dout),
    .mem_din  (mem_din)
  );

  always #5 clk = ~clk;

  // Memory model: asynchronous read, synchronous write, every write logged.
  assign mem_din = ram[mem_adr];
  always @(posedge clk) begin
    if (!reset && mem_rw === 1'b0) begin
      ram[mem_adr] <= mem_dout;
      wr_adr_q.push_back(mem_adr);
      wr_dat_q.push_back(mem_dout);
    end
  end

  function automatic logic [7:0] dat(input logic [15:0] b, input int k);
    return b[7:0] ^ 8'(k * 29 + 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cpu_adr  = 16'h8000;
    cpu_rw   = 1'b1;
    cpu_dout = 8'h00;
    cpu_sync = 1'b0;
    dma_req  = 1'b0;
    dma_last = 1'b0;
    dma_adr  = 16'h0000;
    dma_rw   = 1'b1;
    dma_dout = 8'h00;
  endtask

  // Reset defaults, grant latency, and reset asserted in the middle of a burst.
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    dma_adr = 16'h1234;
    dma_rw  = 1'b0;
    #3;
    total++; if (dma_gnt !== 1'b0) $display("FAIL reset_gnt: got %b expected 0", dma_gnt); else passed++;
    total++; if (cpu_rdy !== 1'b1) $display("FAIL reset_rdy: got %b expected 1", cpu_rdy); else passed++;
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++; if (mem_adr !== 16'h8000) $display("FAIL reset_mem_adr: got %h expected 8000", mem_adr); else passed++;
    total++; if (mem_rw !== 1'b1) $display("FAIL reset_mem_rw: got %b expected 1", mem_rw); else passed++;
    dma_req  = 1'b1;
    cpu_sync = 1'b1;
    tick();
    tick();
    total++; if (dma_gnt !== 1'b0) $display("FAIL latency_early_gnt: got %b expected 0", dma_gnt); else passed++;
    tick();
    total++; if (dma_gnt !== 1'b1) $display("FAIL latency_gnt: got %b expected 1", dma_gnt); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (dma_gnt !== 1'b0) $display("FAIL midburst_gnt: got %b expected 0", dma_gnt); else passed++;
    total++; if (cpu_rdy !== 1'b1) $display("FAIL midburst_rdy: got %b expected 1", cpu_rdy); else passed++;
    total++; if (mem_adr !== 16'h8000) $display("FAIL midburst_mem_adr: got %h expected 8000", mem_adr); else passed++;
    drive_idle();
    tick();
    reset = 1'b0;
    tick();
    total++; if (cpu_rdy !== 1'b1) $display("FAIL post_reset_rdy: got %b expected 1", cpu_rdy); else passed++;
    total++; if (dma_gnt !== 1'b0) $display("FAIL post_reset_gnt: got %b expected 0", dma_gnt); else passed++;
  endtask

  // One full request/grant/return sequence, checked cycle by cycle against a timeline
  // derived from: sync delay s, request length, dma_last position, burst limit.
  task automatic run_burst(input int s, input int req_len, input int last_at,
                           input logic [15:0] base, input bit reraise);
    int  e, g, t, gs, ge, rb, stop_last, k, n;
    bit  by_drop, in_dma, exp_rdy;
    stop_last = (last_at > 0) ? last_at : 1000;
    e = req_len;
    if (stop_last < e) e = stop_last;
    if (LIMIT < e) e = LIMIT;
    by_drop = (req_len < stop_last) && (req_len < LIMIT);
    g  = by_drop ? req_len + 1 : e;
    t  = (s + 1 > 2) ? s + 1 : 2;
    gs = t + 1;
    ge = gs + g;
    rb = ge + 1;
    wr_adr_q.delete();
    wr_dat_q.delete();
    for (int c = 0; c <= rb; c++) begin
      in_dma   = (c >= gs) && (c < ge);
      k        = c - gs;
      cpu_adr  = 16'h8000;
      cpu_dout = 8'hA5;
      cpu_rw   = (c == t || c == ge) ? 1'b0 : 1'b1;
      cpu_sync = (c >= s);
      if (c < gs)      dma_req = 1'b1;
      else if (in_dma) dma_req = (k < req_len);
      else             dma_req = reraise && (c == rb);
      dma_last = in_dma && (k + 1 == last_at);
      dma_adr  = in_dma ? base + 16'(k) : base;
      dma_rw   = !dma_req;
      dma_dout = in_dma ? dat(base, k) : 8'hEE;
      #1;
      exp_rdy = (c == 0) || (c >= rb);
      total++; if (cpu_rdy !== exp_rdy) $display("FAIL burst_rdy base=%h c=%0d: got %b expected %b", base, c, cpu_rdy, exp_rdy); else passed++;
      total++; if (dma_gnt !== in_dma) $display("FAIL burst_gnt base=%h c=%0d: got %b expected %b", base, c, dma_gnt, in_dma); else passed++;
      if (in_dma) begin
        total++; if (mem_adr !== dma_adr) $display("FAIL burst_mem_adr base=%h c=%0d: got %h expected %h", base, c, mem_adr, dma_adr); else passed++;
        total++; if (mem_rw !== dma_rw) $display("FAIL burst_mem_rw base=%h c=%0d: got %b expected %b", base, c, mem_rw, dma_rw); else passed++;
      end else begin
        total++; if (mem_adr !== 16'h8000) $display("FAIL cpu_mem_adr base=%h c=%0d: got %h expected 8000", base, c, mem_adr); else passed++;
      end
      if (c == t || c == ge) begin
        total++; if (mem_rw !== 1'b1) $display("FAIL turn_mem_rw base=%h c=%0d: got %b expected 1", base, c, mem_rw); else passed++;
      end
      if (c == t) begin
        total++; if (mem_dout !== 8'h00) $display("FAIL turn_mem_dout base=%h: got %h expected 00", base, mem_dout); else passed++;
      end
      if (c < rb) tick();
    end
    n = wr_adr_q.size();
    total++; if (n != e) $display("FAIL burst_write_count base=%h: got %0d expected %0d", base, n, e); else passed++;
    for (int i = 0; i < n && i < e; i++) begin
      total++; if (wr_adr_q[i] !== base + 16'(i)) $display("FAIL burst_write_adr base=%h i=%0d: got %h expected %h", base, i, wr_adr_q[i], base + 16'(i)); else passed++;
      total++; if (wr_dat_q[i] !== dat(base, i)) $display("FAIL burst_write_dat base=%h i=%0d: got %h expected %h", base, i, wr_dat_q[i], dat(base, i)); else passed++;
    end
    if (!reraise) begin
      drive_idle();
      repeat (HOLD + 2) tick();
    end
  endtask

  task automatic test_normal_grant();
    run_burst(2, 5, 0, 16'h0100, 1'b0);
  endtask

  task automatic test_burst_limit();
    run_burst(0, 40, 0, 16'h0200, 1'b0);
  endtask

  task automatic test_early_last();
    run_burst(1, 10, 3, 16'h0400, 1'b0);
  endtask

  // Request withdrawn in HALT_WAIT, in the same cycle cpu_sync rises.
  task automatic test_halt_abort();
    drive_idle();
    dma_req = 1'b1;
    tick();
    total++; if (cpu_rdy !== 1'b0) $display("FAIL abort_rdy_fall: got %b expected 0", cpu_rdy); else passed++;
    tick();
    total++; if (dma_gnt !== 1'b0) $display("FAIL abort_gnt_wait: got %b expected 0", dma_gnt); else passed++;
    dma_req  = 1'b0;
    cpu_sync = 1'b1;
    tick();
    total++; if (cpu_rdy !== 1'b1) $display("FAIL abort_rdy_back: got %b expected 1", cpu_rdy); else passed++;
    total++; if (dma_gnt !== 1'b0) $display("FAIL abort_gnt: got %b expected 0", dma_gnt); else passed++;
    tick();
    total++; if (dma_gnt !== 1'b0) $display("FAIL abort_gnt_late: got %b expected 0", dma_gnt); else passed++;
    total++; if (cpu_rdy !== 1'b1) $display("FAIL abort_rdy_late: got %b expected 1", cpu_rdy); else passed++;
    drive_idle();
    tick();
  endtask

  // Request re-raised right after RETURN: ignored for HOLD CPU cycles, CPU works meanwhile.
  task automatic test_holdoff();
    run_burst(0, 2, 2, 16'h0600, 1'b1);
    cpu_adr  = 16'h8000;
    cpu_rw   = 1'b0;
    cpu_dout = 8'h5A;
    cpu_sync = 1'b0;
    for (int j = 1; j <= int'(HOLD) + 1; j++) begin
      tick();
      cpu_rw = 1'b1;
      #1;
      total++; if (cpu_rdy !== (j <= int'(HOLD))) $display("FAIL holdoff_rdy j=%0d: got %b expected %b", j, cpu_rdy, j <= int'(HOLD)); else passed++;
      total++; if (cpu_din !== 8'h5A) $display("FAIL holdoff_cpu_din j=%0d: got %h expected 5a", j, cpu_din); else passed++;
      total++; if (dma_din !== 8'h5A) $display("FAIL holdoff_dma_din j=%0d: got %h expected 5a", j, dma_din); else passed++;
    end
    dma_req = 1'b0;
    tick();
    total++; if (cpu_rdy !== 1'b1) $display("FAIL holdoff_abort_rdy: got %b expected 1", cpu_rdy); else passed++;
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    int s, len, last;
    for (int i = 0; i < 6; i++) begin
      s    = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 24));
      last = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 26)) : 0;
      run_burst(s, len, last, 16'h1000 + 16'(i * 64), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_normal_grant();
    test_burst_limit();
    test_early_last();
    test_halt_abort();
    test_holdoff();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
